// File: rtl/fpu_f2i.sv
// fpu_f2i: multi-cycle float -> two's-complement integer converter.
//
// Takes an FPU-format float {sign, exp, man} (hidden leading 1, bias
// 2**(EXP_W-1)-1) and converts it to a saturated signed integer. Rounding
// is truncation toward zero. The significand is aligned one bit per clock,
// so latency depends on the exponent: done rises N+2 edges after start is
// accepted, where N = |E - MAN_W| for ordinary operands and 0 for specials.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous, active-low reset
//   start       in   conversion request, only honoured while idle
//   op_in       in   float operand, captured on the edge that accepts start
//   busy        out  high while a conversion is in flight
//   done        out  one-cycle pulse; int_out/status_out valid from then on
//   int_out     out  converted integer, held until the next done
//   status_out  out  {invalid, overflow, inexact, zero}, held likewise
module fpu_f2i #(
  parameter int EXP_W = 6,
  parameter int MAN_W = 25,
  parameter int INT_W = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [EXP_W+MAN_W:0] op_in,
  output logic                 busy,
  output logic                 done,
  output logic [INT_W-1:0]     int_out,
  output logic [3:0]           status_out
);

  localparam int FP_W  = 1 + EXP_W + MAN_W;
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int CNT_W = $clog2(INT_W + 1);
  localparam logic [INT_W-1:0] MAX_POS = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] MIN_NEG = {1'b1, {(INT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLASSIFY,
    S_SHIFT,
    S_FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [FP_W-1:0]    op_q, op_d;
  logic [INT_W-1:0]   mag_q, mag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               left_q, left_d;
  logic               sticky_q, sticky_d;
  // special_q: mag_q already holds the final signed result (Inf/NaN,
  // saturation, exact most-negative, zero), so FINISH must not negate it.
  logic               special_q, special_d;
  logic               invalid_q, invalid_d;
  logic               overflow_q, overflow_d;
  logic               inexact_q, inexact_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [INT_W-1:0]   int_q, int_d;
  logic [3:0]         status_q, status_d;

  logic               op_sign;
  logic [EXP_W-1:0]   op_exp;
  logic [MAN_W-1:0]   op_man;
  int                 e_s;
  logic [INT_W-1:0]   res;

  assign op_sign = op_q[FP_W-1];
  assign op_exp  = op_q[MAN_W +: EXP_W];
  assign op_man  = op_q[MAN_W-1:0];

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    mag_d      = mag_q;
    cnt_d      = cnt_q;
    left_d     = left_q;
    sticky_d   = sticky_q;
    special_d  = special_q;
    invalid_d  = invalid_q;
    overflow_d = overflow_q;
    inexact_d  = inexact_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    int_d      = int_q;
    status_d   = status_q;

    // Unbiased exponent; the unsigned field zero-extends into the int.
    e_s = int'(op_exp) - BIAS;
    res = special_q ? mag_q : (op_sign ? -mag_q : mag_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d       = op_in;
          busy_d     = 1'b1;
          sticky_d   = 1'b0;
          special_d  = 1'b0;
          invalid_d  = 1'b0;
          overflow_d = 1'b0;
          inexact_d  = 1'b0;
          state_d    = S_CLASSIFY;
        end
      end

      S_CLASSIFY: begin
        state_d = S_FINISH;
        cnt_d   = '0;
        if (op_exp == '1) begin
          invalid_d = 1'b1;
          special_d = 1'b1;
          mag_d     = op_sign ? MIN_NEG : MAX_POS;
        end else if (op_exp == '0) begin
          // Subnormal/zero encodings: magnitude below 1, sign irrelevant.
          special_d = 1'b1;
          mag_d     = '0;
          inexact_d = |op_man;
        end else if (e_s < 0) begin
          special_d = 1'b1;
          mag_d     = '0;
          inexact_d = 1'b1;
        end else if (e_s >= INT_W - 1) begin
          special_d = 1'b1;
          mag_d     = op_sign ? MIN_NEG : MAX_POS;
          // The only representable value at this exponent is -2**(INT_W-1).
          if (!(op_sign && e_s == INT_W - 1 && op_man == '0)) begin
            overflow_d = 1'b1;
          end
        end else begin
          special_d = 1'b0;
          mag_d     = INT_W'({1'b1, op_man});
          if (e_s > MAN_W) begin
            left_d = 1'b1;
            cnt_d  = CNT_W'(e_s - MAN_W);
          end else begin
            left_d = 1'b0;
            cnt_d  = CNT_W'(MAN_W - e_s);
          end
          if (e_s != MAN_W) begin
            state_d = S_SHIFT;
          end
        end
      end

      S_SHIFT: begin
        if (left_q) begin
          mag_d = mag_q << 1;
        end else begin
          mag_d    = mag_q >> 1;
          sticky_d = sticky_q | mag_q[0];
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FINISH;
        end
      end

      S_FINISH: begin
        int_d    = res;
        status_d = {invalid_q, overflow_q, inexact_q | sticky_q, res == '0};
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      mag_q      <= '0;
      cnt_q      <= '0;
      left_q     <= 1'b0;
      sticky_q   <= 1'b0;
      special_q  <= 1'b0;
      invalid_q  <= 1'b0;
      overflow_q <= 1'b0;
      inexact_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      int_q      <= '0;
      status_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      mag_q      <= mag_d;
      cnt_q      <= cnt_d;
      left_q     <= left_d;
      sticky_q   <= sticky_d;
      special_q  <= special_d;
      invalid_q  <= invalid_d;
      overflow_q <= overflow_d;
      inexact_q  <= inexact_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      int_q      <= int_d;
      status_q   <= status_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign int_out    = int_q;
  assign status_out = status_q;

endmodule

// File: tb/tb_fpu_f2i.sv
// Bench for fpu_f2i at default parameters. Expected results are queued when
// a conversion is started and popped when its done pulse is seen.
module tb_fpu_f2i;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] op_in;
  logic        busy;
  logic        done;
  logic [31:0] int_out;
  logic [3:0]  status_out;

  int total = 0;
  int bad   = 0;

  logic [35:0] exp_q[$];

  fpu_f2i dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .op_in      (op_in),
    .busy       (busy),
    .done       (done),
    .int_out    (int_out),
    .status_out (status_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // Pop the oldest expectation and compare it with the held outputs.
  task automatic check_result(input string name);
    logic [35:0] ent;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s scoreboard: got done with no expected entry", name);
      return;
    end
    ent = exp_q.pop_front();
    total++;
    if (int_out !== ent[35:4]) begin
      bad++;
      $display("FAIL %s int_out: got %h want %h", name, int_out, ent[35:4]);
    end
    total++;
    if (status_out !== ent[3:0]) begin
      bad++;
      $display("FAIL %s status: got %b want %b", name, status_out, ent[3:0]);
    end
    $display("conv %s int=%h status=%b", name, int_out, status_out);
  endtask

  // Wait from the cycle after the accepting edge until done; cyc counts edges
  // after the accepting one, so it equals the documented latency at done.
  task automatic wait_done(input string name, input int e_lat);
    int cyc;
    int busy_low;
    cyc = 0;
    busy_low = 0;
    while (!done && cyc < 100) begin
      if (!busy) busy_low++;
      @(negedge clock);
      cyc++;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s timeout: no done within %0d cycles", name, cyc);
    end
    total++;
    if (cyc != e_lat) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", name, cyc, e_lat);
    end
    total++;
    if (busy_low != 0) begin
      bad++;
      $display("FAIL %s busy_in_flight: low for %0d cycles want 0", name, busy_low);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s busy_at_done: got %b want 0", name, busy);
    end
  endtask

  // Called at a negedge; start is raised for exactly one edge.
  task automatic run_conv(input logic [31:0] op, input logic [31:0] e_int,
                          input logic [3:0] e_st, input int e_lat, input string name);
    exp_q.push_back({e_int, e_st});
    start = 1'b1;
    op_in = op;
    @(negedge clock);
    start = 1'b0;
    op_in = $urandom;
    wait_done(name, e_lat);
    check_result(name);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    op_in = '0;
    repeat (2) @(negedge clock);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", done); end
    total++;
    if (int_out !== 32'h0) begin bad++; $display("FAIL reset int_out: got %h want 0", int_out); end
    total++;
    if (status_out !== 4'b0000) begin bad++; $display("FAIL reset status: got %b want 0000", status_out); end
    $display("reset check busy=%b done=%b int=%h status=%b", busy, done, int_out, status_out);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_normal();
    run_conv(32'h3E000000, 32'h00000001, 4'b0000, 27, "one");
    run_conv(32'hC0000000, 32'hFFFFFFFE, 4'b0000, 26, "minus_two");
    run_conv(32'h3F000000, 32'h00000001, 4'b0010, 27, "one_half_up");
    run_conv(32'hBF000000, 32'hFFFFFFFF, 4'b0010, 27, "minus_1p5");
    run_conv(32'h70000000, 32'h02000000, 4'b0000, 2,  "e25_noshift");
    run_conv(32'h72000000, 32'h04000000, 4'b0000, 3,  "e26_left1");
    run_conv(32'h7BFFFFFF, 32'h7FFFFFE0, 4'b0000, 7,  "max_finite");
    run_conv(32'hF8000000, 32'hE0000000, 4'b0000, 6,  "minus_2p29");
  endtask

  task automatic test_small();
    run_conv(32'h3C000000, 32'h00000000, 4'b0011, 2, "half");
    run_conv(32'h00000000, 32'h00000000, 4'b0001, 2, "pos_zero");
    run_conv(32'h80000000, 32'h00000000, 4'b0001, 2, "neg_zero");
    run_conv(32'h00000001, 32'h00000000, 4'b0011, 2, "denorm");
  endtask

  task automatic test_saturate();
    run_conv(32'h7C000000, 32'h7FFFFFFF, 4'b0100, 2, "ovf_pos");
    run_conv(32'hFC000000, 32'h80000000, 4'b0000, 2, "exact_min");
    run_conv(32'hFC000001, 32'h80000000, 4'b0100, 2, "ovf_neg");
    run_conv(32'h7E000000, 32'h7FFFFFFF, 4'b1000, 2, "inf_pos");
    run_conv(32'hFE000000, 32'h80000000, 4'b1000, 2, "inf_neg");
    run_conv(32'h7E000001, 32'h7FFFFFFF, 4'b1000, 2, "nan_pos");
  endtask

  // Successive run_conv calls raise start in the done cycle itself.
  task automatic test_back_to_back();
    run_conv(32'h3C000000, 32'h00000000, 4'b0011, 2, "b2b_a");
    run_conv(32'h72000000, 32'h04000000, 4'b0000, 3, "b2b_b");
    run_conv(32'hC0000000, 32'hFFFFFFFE, 4'b0000, 26, "b2b_c");
  endtask

  task automatic test_start_held();
    exp_q.push_back({32'h00000001, 4'b0000});
    exp_q.push_back({32'hFFFFFFFE, 4'b0000});
    start = 1'b1;
    op_in = 32'h3E000000;
    @(negedge clock);
    op_in = 32'hC0000000;
    wait_done("held_a", 27);
    check_result("held_a");
    @(negedge clock);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL held_restart busy: got %b want 1", busy);
    end
    wait_done("held_b", 26);
    check_result("held_b");
  endtask

  task automatic test_ignore_start();
    int dones;
    int first;
    exp_q.push_back({32'h00000001, 4'b0000});
    start = 1'b1;
    op_in = 32'h3E000000;
    @(negedge clock);
    start = 1'b0;
    dones = 0;
    first = -1;
    for (int c = 0; c < 60; c++) begin
      if (done) begin
        dones++;
        if (first < 0) first = c;
      end
      start = (c == 5);
      op_in = (c == 5) ? 32'h3C000000 : 32'h0;
      @(negedge clock);
    end
    start = 1'b0;
    total++;
    if (dones != 1) begin bad++; $display("FAIL ignore done_count: got %0d want 1", dones); end
    total++;
    if (first != 27) begin bad++; $display("FAIL ignore latency: got %0d want 27", first); end
    check_result("ignore");
  endtask

  task automatic test_reset_mid();
    int dones;
    start = 1'b1;
    op_in = 32'h3E000000;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL midreset busy: got %b want 0", busy); end
    total++;
    if (int_out !== 32'h0) begin bad++; $display("FAIL midreset int_out: got %h want 0", int_out); end
    total++;
    if (status_out !== 4'b0000) begin bad++; $display("FAIL midreset status: got %b want 0000", status_out); end
    @(negedge clock);
    reset = 1'b1;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) dones++;
      @(negedge clock);
    end
    total++;
    if (dones != 0) begin bad++; $display("FAIL midreset done_count: got %0d want 0", dones); end
    $display("midreset busy=%b int=%h status=%b dones=%0d", busy, int_out, status_out, dones);
    run_conv(32'h3F000000, 32'h00000001, 4'b0010, 27, "after_reset");
  endtask

  initial begin
    test_reset();
    test_normal();
    test_small();
    test_saturate();
    test_back_to_back();
    test_start_held();
    test_ignore_start();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
